// File: rtl/rv_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rv_pkg : shared types for the register-file writeback arbiter            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package rv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    WB_IDLE  = 2'd0,
    WB_PEND  = 2'd1,
    WB_FORCE = 2'd2
  } t_wb_arb_state;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } t_late_wr;

  function automatic logic rd_is_x0(input logic [REG_AW-1:0] rd);
    return rd == '0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rv_late_wr_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rv_late_wr_fifo : in-order buffer of late results with kill-by-rd        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`ifndef RV_DFF_R
`define RV_DFF_R(q, d, rv) \
  always_ff @(posedge clk) begin \
    if (rst) q <= (rv); \
    else     q <= (d); \
  end
`endif

module rv_late_wr_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  t_late_wr          push_entry,
  input  logic              pop,
  input  logic              kill_en,
  input  logic [REG_AW-1:0] kill_rd,
  output t_late_wr          head,
  output logic              full,
  output logic              empty,
  output logic              last
);

  localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  t_late_wr           r_mem     [DEPTH];
  t_late_wr           w_mem_nxt [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr, w_wr_ptr_nxt;
  logic [c_PTR_W-1:0] r_rd_ptr, w_rd_ptr_nxt;
  logic [c_PTR_W:0]   r_count,  w_count_nxt;
  logic               w_push_ok;
  logic               w_pop_ok;

  // DEPTH is a power of two, so the count MSB alone marks full
  assign full  = r_count[c_PTR_W];
  assign empty = (r_count == '0);
  assign last  = (r_count == {{c_PTR_W{1'b0}}, 1'b1});
  assign head  = r_mem[r_rd_ptr];

  assign w_push_ok = push && !full;
  assign w_pop_ok  = pop && !empty;

  assign w_wr_ptr_nxt = w_push_ok ? r_wr_ptr + 1'b1 : r_wr_ptr;
  assign w_rd_ptr_nxt = w_pop_ok  ? r_rd_ptr + 1'b1 : r_rd_ptr;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push_ok, w_pop_ok})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_mem_nxt[i] = r_mem[i];
      if (kill_en && (r_mem[i].rd == kill_rd)) w_mem_nxt[i].valid = 1'b0;
    end
    // caller already folds a same-cycle kill into push_entry.valid
    if (w_push_ok) w_mem_nxt[r_wr_ptr] = push_entry;
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_mem
    `RV_DFF_R(r_mem[g], w_mem_nxt[g], '0)
  end

  `RV_DFF_R(r_wr_ptr, w_wr_ptr_nxt, '0)
  `RV_DFF_R(r_rd_ptr, w_rd_ptr_nxt, '0)
  `RV_DFF_R(r_count,  w_count_nxt,  '0)

endmodule
`default_nettype wire

// File: rtl/rv_rf_wr_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rv_rf_wr_arb : shares one RF write port between WB and late results      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`ifndef RV_DFF_R
`define RV_DFF_R(q, d, rv) \
  always_ff @(posedge clk) begin \
    if (rst) q <= (rv); \
    else     q <= (d); \
  end
`endif

module rv_rf_wr_arb
  import rv_pkg::*;
#(
  parameter int LATE_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_wr_en_Q104H,
  input  logic [REG_AW-1:0] pipe_rd_Q104H,
  input  logic [XLEN-1:0]   pipe_wr_data_Q104H,
  input  logic              late_valid,
  input  logic [REG_AW-1:0] late_rd,
  input  logic [XLEN-1:0]   late_data,
  output logic              late_ready,
  output logic              stall_Q104H,
  output logic              rf_wr_en,
  output logic [REG_AW-1:0] rf_wr_addr,
  output logic [XLEN-1:0]   rf_wr_data
);

  localparam int                 c_CNT_W      = $clog2(STARVE_MAX + 1);
  localparam logic [c_CNT_W-1:0] c_STARVE_MAX = c_CNT_W'(STARVE_MAX);

  t_late_wr           w_head;
  t_late_wr           w_push_entry;
  logic               w_full, w_empty, w_last;
  logic               w_head_live, w_head_dead, w_starved;
  logic               w_grant_late, w_grant_pipe;
  logic               w_pop, w_push, w_kill;
  logic [c_CNT_W-1:0] r_starve_cnt, w_starve_cnt_nxt;
  t_wb_arb_state      r_state, w_state_nxt;

  assign w_head_live = !w_empty && w_head.valid;
  assign w_head_dead = !w_empty && !w_head.valid;
  assign w_starved   = (r_starve_cnt == c_STARVE_MAX);

  // Outputs are masked during reset so a buffered entry can never leak out
  assign w_grant_late = !rst && w_head_live &&
                        (!pipe_wr_en_Q104H || w_full || w_starved);
  assign w_grant_pipe = !rst && pipe_wr_en_Q104H && !w_grant_late;
  assign w_pop        = w_grant_late || w_head_dead;
  assign w_kill       = w_grant_pipe && !rd_is_x0(pipe_rd_Q104H);
  assign w_push       = late_valid && !w_full;

  always_comb begin
    w_push_entry.valid = !rd_is_x0(late_rd) && !(w_kill && (late_rd == pipe_rd_Q104H));
    w_push_entry.rd    = late_rd;
    w_push_entry.data  = late_data;
  end

  assign late_ready  = rst || !w_full;
  assign stall_Q104H = w_grant_late && pipe_wr_en_Q104H;

  always_comb begin
    rf_wr_en   = 1'b0;
    rf_wr_addr = '0;
    rf_wr_data = '0;
    if (w_grant_late) begin
      rf_wr_en   = 1'b1;
      rf_wr_addr = w_head.rd;
      rf_wr_data = w_head.data;
    end else if (w_kill) begin
      rf_wr_en   = 1'b1;
      rf_wr_addr = pipe_rd_Q104H;
      rf_wr_data = pipe_wr_data_Q104H;
    end
  end

  always_comb begin
    w_starve_cnt_nxt = r_starve_cnt;
    if (w_pop || w_empty)  w_starve_cnt_nxt = '0;
    else if (!w_starved)   w_starve_cnt_nxt = r_starve_cnt + 1'b1;
  end

  // FORCE marks the cycle where the starvation limit overrides the pipeline
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      WB_IDLE: if (w_push) w_state_nxt = WB_PEND;
      default: begin
        if (w_pop && w_last && !w_push)                w_state_nxt = WB_IDLE;
        else if (w_starve_cnt_nxt == c_STARVE_MAX)     w_state_nxt = WB_FORCE;
        else                                           w_state_nxt = WB_PEND;
      end
    endcase
  end

  `RV_DFF_R(r_starve_cnt, w_starve_cnt_nxt, '0)
  `RV_DFF_R(r_state,      w_state_nxt,      WB_IDLE)

  rv_late_wr_fifo #(
    .DEPTH (LATE_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (w_push),
    .push_entry (w_push_entry),
    .pop        (w_pop),
    .kill_en    (w_kill),
    .kill_rd    (pipe_rd_Q104H),
    .head       (w_head),
    .full       (w_full),
    .empty      (w_empty),
    .last       (w_last)
  );

endmodule
`default_nettype wire

// File: tb/tb_rv_rf_wr_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rv_rf_wr_arb : cycle-by-cycle vector bench for rv_rf_wr_arb           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_rv_rf_wr_arb;

  typedef struct {
    string       name;
    logic        rst;
    logic        pe;
    logic [4:0]  prd;
    logic [31:0] pd;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic        e_en;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_stall;
    logic        e_ready;
  } t_vec;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pipe_wr_en_Q104H = 1'b0;
  logic [4:0]  pipe_rd_Q104H = '0;
  logic [31:0] pipe_wr_data_Q104H = '0;
  logic        late_valid = 1'b0;
  logic [4:0]  late_rd = '0;
  logic [31:0] late_data = '0;
  logic        late_ready, stall_Q104H, rf_wr_en;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;

  int n_checks = 0;
  int n_errors = 0;

  t_vec vecs[$];
  t_vec sb[$];

  always #5 clk = ~clk;

  rv_rf_wr_arb #(
    .LATE_DEPTH (2),
    .STARVE_MAX (4)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .pipe_wr_en_Q104H   (pipe_wr_en_Q104H),
    .pipe_rd_Q104H      (pipe_rd_Q104H),
    .pipe_wr_data_Q104H (pipe_wr_data_Q104H),
    .late_valid         (late_valid),
    .late_rd            (late_rd),
    .late_data          (late_data),
    .late_ready         (late_ready),
    .stall_Q104H        (stall_Q104H),
    .rf_wr_en           (rf_wr_en),
    .rf_wr_addr         (rf_wr_addr),
    .rf_wr_data         (rf_wr_data)
  );

  function automatic t_vec v(string n, logic r, logic pe, logic [4:0] prd, logic [31:0] pd,
                             logic lv, logic [4:0] lrd, logic [31:0] ld,
                             logic en, logic [4:0] ea, logic [31:0] ed, logic st, logic rdy);
    t_vec t;
    t.name = n; t.rst = r; t.pe = pe; t.prd = prd; t.pd = pd;
    t.lv = lv; t.lrd = lrd; t.ld = ld;
    t.e_en = en; t.e_addr = ea; t.e_data = ed; t.e_stall = st; t.e_ready = rdy;
    return t;
  endfunction

  task automatic chk(input string n, input string f, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s.%s: got %0h expected %0h", n, f, got, exp);
    end
  endtask

  initial begin
    t_vec e;
    // name       rst pe prd pdata          lv lrd ldata          | en addr data          stall ready
    vecs.push_back(v("rst0",  1, 0, 0,  32'h0,        0, 0, 32'h0,           0, 0,  32'h0,        0, 1));
    vecs.push_back(v("rst1",  1, 0, 0,  32'h0,        0, 0, 32'h0,           0, 0,  32'h0,        0, 1));
    // idle pipeline: late result appears the following cycle
    vecs.push_back(v("a_enq", 0, 0, 0,  32'h0,        1, 5, 32'hA5A5_0001,   0, 0,  32'h0,        0, 1));
    vecs.push_back(v("a_wr",  0, 0, 0,  32'h0,        0, 0, 32'h0,           1, 5,  32'hA5A5_0001, 0, 1));
    vecs.push_back(v("a_idl", 0, 0, 0,  32'h0,        0, 0, 32'h0,           0, 0,  32'h0,        0, 1));
    vecs.push_back(v("p_wr",  0, 1, 3,  32'h33,       0, 0, 32'h0,           1, 3,  32'h33,       0, 1));
    // starvation: four waiting cycles, then a forced late write with stall
    vecs.push_back(v("b0",    0, 1, 10, 32'h100,      1, 7, 32'h77,          1, 10, 32'h100,      0, 1));
    vecs.push_back(v("b1",    0, 1, 11, 32'h101,      0, 0, 32'h0,           1, 11, 32'h101,      0, 1));
    vecs.push_back(v("b2",    0, 1, 12, 32'h102,      0, 0, 32'h0,           1, 12, 32'h102,      0, 1));
    vecs.push_back(v("b3",    0, 1, 13, 32'h103,      0, 0, 32'h0,           1, 13, 32'h103,      0, 1));
    vecs.push_back(v("b4",    0, 1, 14, 32'h104,      0, 0, 32'h0,           1, 14, 32'h104,      0, 1));
    vecs.push_back(v("b5",    0, 1, 15, 32'h105,      0, 0, 32'h0,           1, 7,  32'h77,       1, 1));
    vecs.push_back(v("b6",    0, 1, 15, 32'h105,      0, 0, 32'h0,           1, 15, 32'h105,      0, 1));
    vecs.push_back(v("b7",    0, 0, 0,  32'h0,        0, 0, 32'h0,           0, 0,  32'h0,        0, 1));
    // kill: pipeline write to rd 9 drops the buffered rd 9 result
    vecs.push_back(v("c0",    0, 0, 0,  32'h0,        1, 9, 32'hDEAD,        0, 0,  32'h0,        0, 1));
    vecs.push_back(v("c1",    0, 1, 9,  32'h1234,     0, 0, 32'h0,           1, 9,  32'h1234,     0, 1));
    vecs.push_back(v("c2",    0, 1, 20, 32'h2020,     0, 0, 32'h0,           1, 20, 32'h2020,     0, 1));
    vecs.push_back(v("c3",    0, 0, 0,  32'h0,        0, 0, 32'h0,           0, 0,  32'h0,        0, 1));
    vecs.push_back(v("k0",    0, 1, 8,  32'h88,       1, 8, 32'h99,          1, 8,  32'h88,       0, 1));
    vecs.push_back(v("k1",    0, 0, 0,  32'h0,        0, 0, 32'h0,           0, 0,  32'h0,        0, 1));
    // full buffer: third late result held off, head forced out
    vecs.push_back(v("d0",    0, 1, 16, 32'h160,      1, 1, 32'h11,          1, 16, 32'h160,      0, 1));
    vecs.push_back(v("d1",    0, 1, 17, 32'h170,      1, 2, 32'h22,          1, 17, 32'h170,      0, 1));
    vecs.push_back(v("d2",    0, 1, 18, 32'h180,      1, 3, 32'h33,          1, 1,  32'h11,       1, 0));
    vecs.push_back(v("d3",    0, 1, 18, 32'h180,      1, 3, 32'h33,          1, 18, 32'h180,      0, 1));
    vecs.push_back(v("d4",    0, 0, 0,  32'h0,        0, 0, 32'h0,           1, 2,  32'h22,       0, 0));
    vecs.push_back(v("d5",    0, 0, 0,  32'h0,        0, 0, 32'h0,           1, 3,  32'h33,       0, 1));
    vecs.push_back(v("d6",    0, 0, 0,  32'h0,        0, 0, 32'h0,           0, 0,  32'h0,        0, 1));
    // x0 never writes; reset drops buffered entries
    vecs.push_back(v("x0p",   0, 1, 0,  32'hFFFF,     0, 0, 32'h0,           0, 0,  32'h0,        0, 1));
    vecs.push_back(v("x0l",   0, 0, 0,  32'h0,        1, 0, 32'h5,           0, 0,  32'h0,        0, 1));
    vecs.push_back(v("x0i",   0, 0, 0,  32'h0,        0, 0, 32'h0,           0, 0,  32'h0,        0, 1));
    vecs.push_back(v("r0",    0, 1, 21, 32'h210,      1, 4, 32'h44,          1, 21, 32'h210,      0, 1));
    vecs.push_back(v("r1",    0, 1, 22, 32'h220,      1, 6, 32'h66,          1, 22, 32'h220,      0, 1));
    vecs.push_back(v("r2",    1, 0, 0,  32'h0,        0, 0, 32'h0,           0, 0,  32'h0,        0, 1));
    vecs.push_back(v("r3",    0, 0, 0,  32'h0,        0, 0, 32'h0,           0, 0,  32'h0,        0, 1));
    vecs.push_back(v("r4",    0, 0, 0,  32'h0,        0, 0, 32'h0,           0, 0,  32'h0,        0, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst                = vecs[i].rst;
      pipe_wr_en_Q104H   = vecs[i].pe;
      pipe_rd_Q104H      = vecs[i].prd;
      pipe_wr_data_Q104H = vecs[i].pd;
      late_valid         = vecs[i].lv;
      late_rd            = vecs[i].lrd;
      late_data          = vecs[i].ld;
      sb.push_back(vecs[i]);
      #1;
      e = sb.pop_front();
      chk(e.name, "rf_wr_en",    {31'b0, rf_wr_en},    {31'b0, e.e_en});
      chk(e.name, "rf_wr_addr",  {27'b0, rf_wr_addr},  {27'b0, e.e_addr});
      chk(e.name, "rf_wr_data",  rf_wr_data,           e.e_data);
      chk(e.name, "stall_Q104H", {31'b0, stall_Q104H}, {31'b0, e.e_stall});
      chk(e.name, "late_ready",  {31'b0, late_ready},  {31'b0, e.e_ready});
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
